// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the execute stage.
//
// A start pulse in IDLE latches funct3/op_a/op_b. Signed operands are turned
// into magnitudes, and CALC runs one radix-2 step per cycle: shift-add for
// multiplies, restoring division for divides. FIX applies the sign correction
// and selects the result. done pulses for one cycle once the result is stable.
// Divide-by-zero and signed overflow finish straight away.
//
// Optional build macro FAST_MUL_EN: multiplies use a combinational multiplier
// and take the path IDLE -> FIX -> DONE. Divides are unchanged.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   start    issue request, sampled only in IDLE
//   funct3   RV M-extension operation select
//   op_a     rs1 operand (multiplicand / dividend)
//   op_b     rs2 operand (multiplier / divisor)
//   kill     pipeline flush; aborts the operation in flight
//   busy     high in CALC and FIX
//   done     one-cycle result-valid pulse
//   result   final result, held until overwritten by a later operation
//   div_zero divisor was zero on a divide/remainder op (valid with done)
module riscv_muldiv_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              kill,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              div_zero
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;
  state_e state_q, state_d;

  logic [2:0]          op_q;
  logic                sign_a_q, sign_b_q;
  logic [DATA_W-1:0]   mag_b_q;
  // Multiply: {partial product, multiplier}. Divide: low half is dividend/quotient.
  logic [2*DATA_W-1:0] acc_q;
  logic [DATA_W-1:0]   rem_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   result_q;
  logic                done_q, div_zero_q;

  // Issue-time decode
  logic              is_div, signed_a, signed_b, op_sign_a, op_sign_b;
  logic              b_zero, sdiv_ovf, special, accept, fast_mul;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic [2*DATA_W-1:0] acc_init;

  assign is_div    = funct3[2];
  assign signed_a  = (funct3 == 3'b001) | (funct3 == 3'b010) |
                     (funct3 == 3'b100) | (funct3 == 3'b110);
  assign signed_b  = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
  assign op_sign_a = signed_a & op_a[DATA_W-1];
  assign op_sign_b = signed_b & op_b[DATA_W-1];
  // The most negative value maps to its unsigned magnitude 2^(DATA_W-1).
  assign mag_a     = op_sign_a ? -op_a : op_a;
  assign mag_b     = op_sign_b ? -op_b : op_b;
  assign b_zero    = (op_b == '0);
  assign sdiv_ovf  = is_div & signed_b & (op_a == {1'b1, {(DATA_W-1){1'b0}}}) & (op_b == '1);
  assign special   = is_div & (b_zero | sdiv_ovf);
  assign accept    = start & ~kill;

`ifdef FAST_MUL_EN
  logic [2*DATA_W-1:0] ext_a, ext_b, fast_prod;
  assign ext_a     = {{DATA_W{op_sign_a}}, op_a};
  assign ext_b     = {{DATA_W{op_sign_b}}, op_b};
  assign fast_prod = ext_a * ext_b;
  assign fast_mul  = ~is_div;
  assign acc_init  = fast_mul ? fast_prod : {{DATA_W{1'b0}}, mag_a};
`else
  assign fast_mul  = 1'b0;
  assign acc_init  = {{DATA_W{1'b0}}, mag_a};
`endif

  // Multiply step: add the multiplicand into the upper half if the LSB is set, then shift.
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_step;
  assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} +
                    (acc_q[0] ? {1'b0, mag_b_q} : {(DATA_W+1){1'b0}});
  assign mul_step = {mul_sum, acc_q[DATA_W-1:1]};

  // Restoring divide step on the (DATA_W+1)-bit shifted partial remainder.
  logic [DATA_W:0]   div_shift;
  logic [DATA_W-1:0] div_diff;
  logic              div_borrow, div_ge;
  assign div_shift              = {rem_q, acc_q[DATA_W-1]};
  assign {div_borrow, div_diff} = {1'b0, div_shift[DATA_W-1:0]} - {1'b0, mag_b_q};
  assign div_ge                 = div_shift[DATA_W] | ~div_borrow;

  // Sign correction and result select
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix, fix_result;
  assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
  assign quo_fix  = (sign_a_q ^ sign_b_q) ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
  assign rem_fix  = sign_a_q ? -rem_q : rem_q;

  always_comb begin
    fix_result = rem_fix;
    unique case (op_q)
      3'b000:                 fix_result = prod_fix[DATA_W-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*DATA_W-1:DATA_W];
      3'b100, 3'b101:         fix_result = quo_fix;
      default:                fix_result = rem_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (special)       state_d = StDone;
          else if (fast_mul) state_d = StFix;
          else               state_d = StCalc;
        end
      end
      StCalc: begin
        if (kill)                       state_d = StIdle;
        else if (cnt_q == CNT_W'(1))    state_d = StFix;
      end
      StFix:   state_d = kill ? StIdle : StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q       <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      mag_b_q    <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      // The pulse follows the DONE cycle, so the result register is already settled.
      done_q <= (state_q == StDone);
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_q       <= funct3;
            sign_a_q   <= op_sign_a & ~fast_mul;
            sign_b_q   <= op_sign_b & ~fast_mul;
            mag_b_q    <= mag_b;
            acc_q      <= acc_init;
            rem_q      <= '0;
            cnt_q      <= CNT_W'(DATA_W);
            div_zero_q <= is_div & b_zero;
            if (is_div && b_zero) begin
              result_q <= funct3[1] ? op_a : '1;
            end else if (sdiv_ovf) begin
              result_q <= funct3[1] ? '0 : op_a;
            end
          end
        end
        StCalc: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (op_q[2]) begin
            rem_q              <= div_ge ? div_diff : div_shift[DATA_W-1:0];
            acc_q[DATA_W-1:0]  <= {acc_q[DATA_W-2:0], div_ge};
          end else begin
            acc_q <= mul_step;
          end
        end
        StFix: begin
          if (!kill) result_q <= fix_result;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q == StCalc) | (state_q == StFix);
  assign done     = done_q;
  assign result   = result_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Self-checking bench for riscv_muldiv_unit (DATA_W = 32): vector table,
// model-driven random operations, and kill / busy-start / reset sequences.
module tb_riscv_muldiv_unit;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, start, kill;
  logic [2:0]   funct3;
  logic [W-1:0] op_a, op_b, result;
  logic         busy, done, div_zero;

  riscv_muldiv_unit #(.DATA_W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .funct3   (funct3),
    .op_a     (op_a),
    .op_b     (op_b),
    .kill     (kill),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, sq;
    logic [63:0]        ua, ub, p;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        sq = sa / sb; return sq[31:0];
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'b110: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        sq = sa % sb; return sq[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b);
    logic ovf;
    ovf = ((f == 3'b100) || (f == 3'b110)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (f[2] && ((b == 0) || ovf)) return 1;
`ifdef FAST_MUL_EN
    if (!f[2]) return 2;
`endif
    return W + 2;
  endfunction

  // Drives start across one rising edge (edge 0); returns 1 ns after it.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic dz);
    exp_t e;
    e.res = res;
    e.dz  = dz;
    e.lat = exp_lat(f, a, b);
    sb_q.push_back(e);
    @(negedge clk);
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for done, counting edges from the start edge; edges_done already elapsed.
  task automatic wait_done(input string name, input int edges_done);
    exp_t e;
    int   n;
    bit   seen;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e    = sb_q.pop_front();
    n    = edges_done;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, seen, 1);
    if (seen) begin
      chk({name, "_result"}, result, e.res);
      chk({name, "_div_zero"}, div_zero, e.dz);
      chk({name, "_latency"}, n, e.lat);
      @(posedge clk);
      #1;
      chk({name, "_done_width"}, done, 0);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic dz);
    issue(f, a, b, res, dz);
    chk({name, "_busy"}, busy, exp_lat(f, a, b) > 1);
    wait_done(name, 0);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk(name, seen, 0);
  endtask

  initial begin
    vec_t        vt[11];
    exp_t        dropped;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    vt[0]  = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    vt[1]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vt[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vt[3]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
    vt[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
    vt[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
    vt[6]  = '{3'b101, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003, 1'b0};
    vt[7]  = '{3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
    vt[8]  = '{3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b1};
    vt[9]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
    vt[10] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};

    reset  = 1'b0;
    start  = 1'b0;
    kill   = 1'b0;
    funct3 = 3'b000;
    op_a   = '0;
    op_b   = '0;
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_div_zero", div_zero, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), vt[i].f, vt[i].a, vt[i].b, vt[i].res, vt[i].dz);
    end

    for (int i = 0; i < 16; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_op($sformatf("rnd%0d", i), rf, ra, rb, model(rf, ra, rb),
             rf[2] && (rb == 0));
    end

    // Kill mid-CALC: no done, result keeps the previous value.
    run_op("pre_kill", 3'b101, 32'd7, 32'd2, 32'd3, 1'b0);
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'b101;
    op_a   = 32'd100;
    op_b   = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("kill_busy_before", busy, 1);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    chk("kill_busy_after", busy, 0);
    chk("kill_done", done, 0);
    chk("kill_result_held", result, 32'd3);
    expect_quiet("kill_no_done", 40);

    run_op("reissue", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0);

    // Start while busy is dropped without queueing.
    issue(3'b101, 32'd100, 32'd7, 32'd14, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'b000;
    op_a   = 32'd3;
    op_b   = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("busy_start", 5);
    expect_quiet("busy_start_no_extra", 40);

    // Asynchronous reset mid-CALC.
    run_op("pre_reset", 3'b111, 32'd9, 32'd0, 32'd9, 1'b1);
    issue(3'b101, 32'd100, 32'd7, 32'd14, 1'b0);
    dropped = sb_q.pop_front();
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_result", result, 0);
    chk("rst_mid_div_zero", div_zero, 0);
    @(negedge clk);
    reset = 1'b1;
    run_op("post_reset", 3'b000, 32'd6, 32'd7, 32'd42, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
